// File: rtl/nochange_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nochange_pkg : shared types and widths for the nochange window monitor   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package nochange_pkg;

    typedef enum logic [1:0] {
        NC_IDLE = 2'd0,
        NC_OPEN = 2'd1,
        NC_TAIL = 2'd2
    } nc_state_t;

    localparam int OFS_W = 4;
    // Tail counter holds START_OFS+END_OFS-1, at most 2*(2^OFS_W-1)-1.
    localparam int TAIL_W = OFS_W + 1;

endpackage
`default_nettype wire

// File: rtl/nochange_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nochange_channel : one channel of the clocked $nochange monitor          |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module nochange_channel
    import nochange_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int START_OFS = 0,
    parameter int END_OFS   = 0,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              pol,
    input  logic              ref_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              window_open,
    output logic              viol_pulse,
    output logic              viol_sticky,
    output logic [CNT_W-1:0]  viol_cnt
);

    localparam int EXT = START_OFS + END_OFS;
    localparam logic [TAIL_W-1:0] TAIL_LOAD = (EXT > 1) ? TAIL_W'(EXT - 1) : '0;

    logic              ref_q;
    logic              pol_q;
    logic [DATA_W-1:0] data_q;
    nc_state_t         state_q, state_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              pulse_q;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic pol_act;
    logic ref_edge;
    logic lead;
    logic trail;
    logic chg;
    logic chg_d;
    logic in_window;
    logic viol;

    // Polarity is frozen for the lifetime of a window.
    always_comb begin
        pol_act  = (state_q == NC_IDLE) ? pol : pol_q;
        ref_edge = ref_i ^ ref_q;
        lead     = ref_edge & (ref_i == pol_act);
        trail    = ref_edge & (ref_i != pol_act);
        chg      = (data_i != data_q);
    end

    generate
        if (START_OFS == 0) begin : g_no_delay
            assign chg_d = chg;
        end else begin : g_delay
            logic [START_OFS-1:0] dly_q;
            always_ff @(posedge clk) begin
                if (!rst_n || !en) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= START_OFS'({dly_q, chg});
                end
            end
            assign chg_d = dly_q[START_OFS-1];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        tail_d    = tail_q;
        in_window = 1'b0;
        case (state_q)
            NC_OPEN: begin
                // With no extension the trailing-edge cycle is outside the open interval.
                in_window = !(trail && (EXT == 0));
                if (trail) begin
                    if (EXT > 1) begin
                        state_d = NC_TAIL;
                        tail_d  = TAIL_LOAD;
                    end else begin
                        state_d = NC_IDLE;
                    end
                end
            end
            NC_TAIL: begin
                in_window = 1'b1;
                if (lead) begin
                    state_d = NC_OPEN;
                end else if (tail_q < TAIL_W'(2)) begin
                    state_d = NC_IDLE;
                end else begin
                    tail_d = tail_q - 1'b1;
                end
            end
            default: begin
                state_d = lead ? NC_OPEN : NC_IDLE;
            end
        endcase
        if (!en) begin
            state_d = NC_IDLE;
            tail_d  = '0;
        end
        viol = en & chg_d & in_window;
    end

    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (viol) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // History registers load live inputs in reset so no edge is seen afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q    <= ref_i;
            data_q   <= data_i;
            pol_q    <= pol;
            state_q  <= NC_IDLE;
            tail_q   <= '0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            ref_q    <= ref_i;
            data_q   <= data_i;
            pol_q    <= pol_act;
            state_q  <= state_d;
            tail_q   <= tail_d;
            pulse_q  <= viol;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign window_open = (state_q != NC_IDLE);
    assign viol_pulse  = pulse_q;
    assign viol_sticky = sticky_q;
    assign viol_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: rtl/nochange_window_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nochange_window_monitor : multi-channel run-time $nochange monitor       |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module nochange_window_monitor
    import nochange_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 8,
    parameter int START_OFS = 0,
    parameter int END_OFS   = 0,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic [NUM_CH-1:0]        pol,
    input  logic [NUM_CH-1:0]        ref_i,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic [NUM_CH-1:0]        window_open,
    output logic [NUM_CH-1:0]        viol_pulse,
    output logic [NUM_CH-1:0]        viol_sticky,
    output logic [NUM_CH*CNT_W-1:0]  viol_cnt,
    output logic                     any_viol
);

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            nochange_channel #(
                .DATA_W    (DATA_W),
                .START_OFS (START_OFS),
                .END_OFS   (END_OFS),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .en          (en),
                .clr         (clr),
                .pol         (pol[c]),
                .ref_i       (ref_i[c]),
                .data_i      (data_i[c*DATA_W +: DATA_W]),
                .window_open (window_open[c]),
                .viol_pulse  (viol_pulse[c]),
                .viol_sticky (viol_sticky[c]),
                .viol_cnt    (viol_cnt[c*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign any_viol = |viol_sticky;

endmodule
`default_nettype wire

// File: tb/tb_nochange_window_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nochange_window_monitor : directed + random bench, two configurations |
// | Revision                   : 1.0                                         |
// +--------------------------------------------------------------------------+
module tb_nochange_window_monitor;

    logic        clk = 1'b0;
    logic        rst_n, en, clr;
    logic [3:0]  pol, ref_v;
    logic [31:0] data_v;

    logic [3:0]  wo_a, vp_a, vs_a;
    logic [31:0] vc_a;
    logic        av_a;
    logic [3:0]  wo_b, vp_b, vs_b;
    logic [7:0]  vc_b;
    logic        av_b;

    always #5 clk = ~clk;

    nochange_window_monitor #(.NUM_CH(4), .DATA_W(8), .START_OFS(0), .END_OFS(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .pol(pol), .ref_i(ref_v), .data_i(data_v),
        .window_open(wo_a), .viol_pulse(vp_a), .viol_sticky(vs_a), .viol_cnt(vc_a), .any_viol(av_a));

    nochange_window_monitor #(.NUM_CH(4), .DATA_W(8), .START_OFS(3), .END_OFS(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .pol(pol), .ref_i(ref_v), .data_i(data_v),
        .window_open(wo_b), .viol_pulse(vp_b), .viol_sticky(vs_b), .viol_cnt(vc_b), .any_viol(av_b));

    int n_cmp, n_mis;

    // Reference model: input history plus a list of [lead, trail] windows per channel.
    logic [31:0] data_h [0:1023];
    logic [3:0]  ref_prev;
    logic [3:0]  pol_m;
    int          lead_a  [4][256];
    int          trail_a [4][256];
    int          nwin    [4];
    int          t;
    int          cnt_m    [2][4];
    bit          sticky_m [2][4];

    task automatic chk(input string name, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL t=%0d %s[%0d]: observed %0h expected %0h", t, name, ch, obs, exp);
        end
    endtask

    task automatic record_cycle();
        data_h[t] = data_v;
        if (t > 0) begin
            for (int ch = 0; ch < 4; ch++) begin
                if (ref_v[ch] != ref_prev[ch]) begin
                    if (ref_v[ch] == pol_m[ch]) begin
                        if (nwin[ch] < 256) begin
                            lead_a[ch][nwin[ch]]  = t;
                            trail_a[ch][nwin[ch]] = -1;
                            nwin[ch]++;
                        end
                    end else if (nwin[ch] > 0 && trail_a[ch][nwin[ch]-1] < 0) begin
                        trail_a[ch][nwin[ch]-1] = t;
                    end
                end
            end
        end
        ref_prev = ref_v;
    endtask

    // Change at cycle c violates iff lead-S < c < trail+E for some window.
    function automatic bit exp_viol(input int ch, input int s, input int e);
        int c;
        c = t - s;
        if (c < 1) return 1'b0;
        if (data_h[c][ch*8 +: 8] == data_h[c-1][ch*8 +: 8]) return 1'b0;
        for (int k = 0; k < nwin[ch]; k++) begin
            if (lead_a[ch][k] < t && (trail_a[ch][k] < 0 || c < trail_a[ch][k] + e)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Next cycle is inside the checked span lead+1 .. trail+E+S-1.
    function automatic bit exp_open(input int ch, input int s, input int e);
        for (int k = 0; k < nwin[ch]; k++) begin
            if (lead_a[ch][k] <= t &&
                (trail_a[ch][k] < 0 || t + 1 <= trail_a[ch][k] + e + s - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step();
        logic [3:0] ep [2];
        logic [3:0] ew [2];
        logic [3:0] es [2];
        int s, e, mx;
        bit v;
        if (!rst_n) begin
            t = 0;
            for (int ch = 0; ch < 4; ch++) nwin[ch] = 0;
            for (int g = 0; g < 2; g++) begin
                for (int ch = 0; ch < 4; ch++) begin
                    cnt_m[g][ch]    = 0;
                    sticky_m[g][ch] = 1'b0;
                end
                ep[g] = 4'h0;
                ew[g] = 4'h0;
            end
            record_cycle();
        end else begin
            t++;
            record_cycle();
            for (int g = 0; g < 2; g++) begin
                s  = (g == 1) ? 3 : 0;
                e  = (g == 1) ? 2 : 0;
                mx = (g == 1) ? 3 : 255;
                for (int ch = 0; ch < 4; ch++) begin
                    v          = en ? exp_viol(ch, s, e) : 1'b0;
                    ep[g][ch]  = v;
                    ew[g][ch]  = en ? exp_open(ch, s, e) : 1'b0;
                    if (clr) begin
                        cnt_m[g][ch]    = 0;
                        sticky_m[g][ch] = 1'b0;
                    end else if (v) begin
                        sticky_m[g][ch] = 1'b1;
                        if (cnt_m[g][ch] < mx) cnt_m[g][ch]++;
                    end
                end
            end
        end
        for (int g = 0; g < 2; g++)
            for (int ch = 0; ch < 4; ch++) es[g][ch] = sticky_m[g][ch];
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 4; ch++) begin
            chk("A.pulse",  ch, 32'(vp_a[ch]), 32'(ep[0][ch]));
            chk("A.window", ch, 32'(wo_a[ch]), 32'(ew[0][ch]));
            chk("A.sticky", ch, 32'(vs_a[ch]), 32'(es[0][ch]));
            chk("A.cnt",    ch, 32'(vc_a[ch*8 +: 8]), 32'(cnt_m[0][ch]));
            chk("B.pulse",  ch, 32'(vp_b[ch]), 32'(ep[1][ch]));
            chk("B.window", ch, 32'(wo_b[ch]), 32'(ew[1][ch]));
            chk("B.sticky", ch, 32'(vs_b[ch]), 32'(es[1][ch]));
            chk("B.cnt",    ch, 32'(vc_b[ch*2 +: 2]), 32'(cnt_m[1][ch]));
        end
        chk("A.any", 0, 32'(av_a), 32'(|es[0]));
        chk("B.any", 0, 32'(av_b), 32'(|es[1]));
    endtask

    task automatic do_reset(input logic [3:0] p, input logic [3:0] r, input logic [31:0] d);
        pol   = p;
        pol_m = p;
        ref_v = r;
        data_v = d;
        en    = 1'b1;
        clr   = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        t     = 0;

        // Coincident edges, pol=0 channel, pre-window extension (dut_b), post-window tail.
        do_reset(4'b1101, 4'b0010, 32'h0);
        for (int k = 1; k <= 30; k++) begin
            ref_v[0] = (k >= 10 && k < 20);
            ref_v[1] = !(k >= 5 && k < 9);
            ref_v[2] = (k >= 10 && k < 20);
            ref_v[3] = 1'b0;
            data_v[7:0]   = (k < 10) ? 8'h00 : (k < 15) ? 8'h5A : (k < 21) ? 8'hA5 : (k < 22) ? 8'h11 : 8'h22;
            data_v[15:8]  = (k < 7) ? 8'h00 : 8'h33;
            data_v[23:16] = (k < 7) ? 8'd0 : (k < 8) ? 8'd1 : 8'd2;
            step();
            if (k == 7)  chk("s1.A.pulse_ch1", 1, 32'(vp_a[1]), 32'd1);
            if (k == 10) chk("s1.A.pulse_lead", 0, 32'(vp_a[0]), 32'd0);
            if (k == 10) chk("s1.B.pulse_early", 2, 32'(vp_b[2]), 32'd0);
            if (k == 11) chk("s1.B.pulse_pre", 2, 32'(vp_b[2]), 32'd1);
            if (k == 15) chk("s1.A.pulse_mid", 0, 32'(vp_a[0]), 32'd1);
            if (k == 16) chk("s1.A.cnt", 0, 32'(vc_a[7:0]), 32'd1);
            if (k == 20) chk("s1.A.pulse_trail", 0, 32'(vp_a[0]), 32'd0);
        end
        chk("s1.A.sticky", 0, 32'(vs_a), 32'h3);
        chk("s1.B.sticky", 0, 32'(vs_b), 32'h7);
        chk("s1.A.any",    0, 32'(av_a), 32'd1);

        // Saturation of the 2-bit counter, then clr coincident with a violation.
        do_reset(4'hF, 4'h0, 32'h0);
        for (int k = 1; k <= 14; k++) begin
            ref_v       = {3'b000, (k >= 2)};
            data_v[7:0] = (k >= 3 && k <= 8) ? 8'(k) : ((k > 8) ? 8'd8 : 8'd0);
            clr         = (k == 11);
            step();
            if (k == 8)  chk("s2.A.cnt", 0, 32'(vc_a[7:0]), 32'd6);
            if (k == 10) chk("s2.B.cnt_sat", 0, 32'(vc_b[1:0]), 32'd3);
            if (k == 11) chk("s2.B.cnt_clr", 0, 32'(vc_b[1:0]), 32'd0);
            if (k == 11) chk("s2.B.sticky_clr", 0, 32'(vs_b[0]), 32'd0);
        end
        clr = 1'b0;

        // Reset asserted inside an open window with toggling data.
        do_reset(4'hF, 4'h0, 32'h0);
        for (int k = 1; k <= 13; k++) begin
            ref_v       = {3'b000, (k >= 3)};
            data_v[7:0] = 8'(k);
            step();
        end
        rst_n       = 1'b0;
        data_v[7:0] = 8'd14;
        step();
        rst_n = 1'b1;
        chk("s3.A.cnt",    0, vc_a, 32'd0);
        chk("s3.A.window", 0, 32'(wo_a), 32'd0);
        chk("s3.A.pulse",  0, 32'(vp_a), 32'd0);
        chk("s3.B.pulse",  0, 32'(vp_b), 32'd0);
        chk("s3.A.any",    0, 32'(av_a), 32'd0);
        for (int k = 15; k <= 20; k++) begin
            data_v[7:0] = 8'(k);
            step();
        end
        chk("s3.A.sticky", 0, 32'(vs_a), 32'd0);

        // Monitor disabled mid-window: no pulses, counters held.
        do_reset(4'hF, 4'h0, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            ref_v       = {3'b000, (k >= 2)};
            data_v[7:0] = (k >= 5) ? 8'd2 : ((k >= 4) ? 8'd1 : 8'd0);
            step();
        end
        en = 1'b0;
        for (int k = 10; k <= 20; k++) begin
            ref_v       = {3'b000, !(k >= 12 && k < 15)};
            data_v[7:0] = 8'(k);
            step();
        end
        chk("s4.A.cnt",    0, 32'(vc_a[7:0]), 32'd2);
        chk("s4.B.cnt",    0, 32'(vc_b[1:0]), 32'd2);
        chk("s4.A.pulse",  0, 32'(vp_a), 32'd0);
        chk("s4.A.window", 0, 32'(wo_a), 32'd0);
        en = 1'b1;

        // Random traffic on all channels against the window model.
        do_reset(4'($urandom), 4'($urandom), $urandom);
        for (int k = 1; k <= 300; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 4) == 0) ref_v[ch] = ~ref_v[ch];
                if ($urandom_range(0, 3) == 0) data_v[ch*8 +: 8] = 8'($urandom);
            end
            clr = ($urandom_range(0, 49) == 0);
            step();
        end
        clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
